// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
// Bundles the signals between a PS/2 host transmitter and its surroundings.
//   tx_data/tx_valid/tx_ready : byte handshake from the command source
//   busy/tx_done/tx_error     : transfer status (busy also gates the keyboard receiver)
//   PS2_clk/PS2_data          : sensed open-collector PS/2 lines
//   PS2_clk_oe/PS2_data_oe    : active-high pull-low enables for those lines
// The slave modport is the transmitter; master is the side that feeds it.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       PS2_clk;
  logic       PS2_data;
  logic       PS2_clk_oe;
  logic       PS2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid, PS2_clk, PS2_data,
    input  tx_ready, PS2_clk_oe, PS2_data_oe, busy, tx_done, tx_error
  );

  modport slave (
    input  tx_data, tx_valid, PS2_clk, PS2_data,
    output tx_ready, PS2_clk_oe, PS2_data_oe, busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Holds the clock low to inhibit the device,
// raises a request (start bit), then presents data bits LSB first, odd parity
// and a released stop bit on device-generated falling clock edges, and finally
// samples the device acknowledge.
//   system_clk : system clock, all logic on the rising edge
//   reset      : asynchronous, active-low reset
//   bus        : ps2_host_tx_if.slave (handshake, status and PS/2 line signals)
// Parameters:
//   INHIBIT_CYCLES : cycles PS2_clk is held low before the request
//   TIMEOUT_CYCLES : cycles allowed from clock release to acknowledge
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic         system_clk,
  input  logic         reset,
  ps2_host_tx_if.slave bus
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic [2:0]       clk_pipe;
  logic [1:0]       data_pipe;
  logic             clk_s;
  logic             data_s;
  logic             clk_fall;
  logic             timeout;
  logic             timed_state;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [3:0]       bit_cnt;
  logic [8:0]       shift_reg;
  logic             clk_oe_r;
  logic             data_oe_r;
  logic             done_r;
  logic             error_r;

  // Two-flop synchronizers; clk_pipe[2] keeps the previous synced clock so a
  // falling edge shows up as a one-cycle strobe.
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      clk_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      clk_pipe  <= {clk_pipe[1:0], bus.PS2_clk};
      data_pipe <= {data_pipe[0], bus.PS2_data};
    end
  end

  assign clk_s       = clk_pipe[1];
  assign data_s      = data_pipe[1];
  assign clk_fall    = clk_pipe[2] & ~clk_pipe[1];
  assign timed_state = (state == REQ) || (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign timeout     = timed_state && (tmo_cnt == TMO_LAST);

  // Transfer sequencer. The timeout check sits ahead of the state case so a
  // falling edge arriving in the timeout cycle is ignored.
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      inh_cnt   <= '0;
      tmo_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      clk_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      error_r <= 1'b0;
      if (timed_state && !timeout) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (timeout) begin
        clk_oe_r  <= 1'b0;
        data_oe_r <= 1'b0;
        error_r   <= 1'b1;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.tx_valid && bus.tx_ready) begin
              shift_reg <= {~^bus.tx_data, bus.tx_data};
              inh_cnt   <= '0;
              clk_oe_r  <= 1'b1;
              data_oe_r <= 1'b0;
              state     <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              clk_oe_r  <= 1'b0;
              data_oe_r <= 1'b1;
              bit_cnt   <= '0;
              tmo_cnt   <= '0;
              state     <= REQ;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          REQ: begin
            if (clk_fall) begin
              data_oe_r <= ~shift_reg[0];
              shift_reg <= {1'b0, shift_reg[8:1]};
              bit_cnt   <= 4'd1;
              state     <= SEND;
            end
          end
          SEND: begin
            // bit_cnt 1..8 present data bits 1..7 and parity; 9 releases for stop
            if (clk_fall) begin
              if (bit_cnt == 4'd9) begin
                data_oe_r <= 1'b0;
                state     <= ACK;
              end else begin
                data_oe_r <= ~shift_reg[0];
                shift_reg <= {1'b0, shift_reg[8:1]};
              end
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ACK: begin
            if (clk_fall) begin
              if (!data_s) begin
                done_r <= 1'b1;
              end else begin
                error_r <= 1'b1;
              end
              clk_oe_r  <= 1'b0;
              data_oe_r <= 1'b0;
              state     <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (clk_s && data_s) begin
              state <= IDLE;
            end
          end
          default: begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.tx_ready    = (state == IDLE) && clk_s && data_s;
  assign bus.busy        = (state != IDLE);
  assign bus.PS2_clk_oe  = clk_oe_r;
  assign bus.PS2_data_oe = data_oe_r;
  assign bus.tx_done     = done_r;
  assign bus.tx_error    = error_r;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device transmitter for the PS/2 port. Sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives the open-collector PS2_clk/PS2_data lines through active-high pull-low enables. Follows the device-clocked host-request protocol and reports device acknowledge or failure.
- Sits beside the keyboard receiver. Its busy output gates that receiver during a host transmission.

Parameters:
- INHIBIT_CYCLES, 5000, system_clk cycles PS2_clk is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, maximum system_clk cycles from release of PS2_clk to acknowledge (15 ms at 50 MHz).

Ports:
- system_clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tx_data  input  8  command byte to send.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  block can accept a byte this cycle.
- PS2_clk  input  1  sensed PS/2 clock line (asynchronous).
- PS2_data  input  1  sensed PS/2 data line (asynchronous).
- PS2_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release.
- PS2_data_oe  output  1  1 = pull PS/2 data low; 0 = release.
- busy  output  1  transmission in progress (any state but IDLE).
- tx_done  output  1  one-cycle pulse: device acknowledged (ack bit = 0).
- tx_error  output  1  one-cycle pulse: no acknowledge, or timeout.

Behaviour:
- Reset (async, reset=0):
  - PS2_clk_oe=0, PS2_data_oe=0, tx_ready=0, busy=0, tx_done=0, tx_error=0.
  - State=IDLE; counters and shift register cleared.
  - Reset mid-frame releases both lines immediately.
- Input sync:
  - PS2_clk and PS2_data each pass a 2-flop synchronizer.
  - Falling edge = previous synced clk 1 and current synced clk 0. It is a one-cycle strobe, 3 cycles after the line edge.
- Handshake:
  - tx_ready=1 only in IDLE with synced clk=1 and synced data=1 (bus idle).
  - Byte accepted on tx_valid & tx_ready.
  - Accept cycle latches tx_data and odd parity (parity = ~^tx_data), then enters INHIBIT.
  - tx_valid outside tx_ready is ignored; no queueing.
- States:
  - IDLE: both oe=0.
  - INHIBIT: PS2_clk_oe=1, PS2_data_oe=0, for exactly INHIBIT_CYCLES cycles. Then -> REQ.
  - REQ: PS2_data_oe=1 (start bit 0) in the same cycle PS2_clk_oe drops to 0. Clear bit_cnt and the timeout counter. On falling edge -> SEND.
  - SEND: on each falling edge, present the next frame bit by setting PS2_data_oe = ~bit.
    - Order: data bits 0..7 LSB first (bit_cnt 0-7), parity (bit_cnt 8), stop = release data (bit_cnt 9).
    - The first falling edge in REQ presents data bit 0.
    - After the stop bit is presented -> ACK.
  - ACK: on the next falling edge, sample synced data.
    - 0 -> pulse tx_done, go to WAIT_IDLE.
    - 1 -> pulse tx_error, go to WAIT_IDLE.
  - WAIT_IDLE: both oe=0. When synced clk=1 and data=1 -> IDLE.
- Timeout:
  - Counter runs in REQ, SEND, ACK, WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES: both oe=0, pulse tx_error, go to IDLE.
  - Counter width is enough for TIMEOUT_CYCLES; it never wraps.
  - A falling edge in the same cycle as timeout: timeout wins.
- Mutual exclusion: tx_done and tx_error are never high in the same cycle. Each pulse lasts exactly 1 cycle.
- Device abort: a device-held clk during INHIBIT is not an error; INHIBIT still counts the full INHIBIT_CYCLES.
- Data line: PS2_data_oe changes only on a falling-edge strobe, or on entry to REQ, WAIT_IDLE, or IDLE.

Test Plan (INHIBIT_CYCLES=8, TIMEOUT_CYCLES=2000; device model clocks at 40 system_clk period and samples data on rising edges):
- Send 0xED, device acks -> sampled bits 1,0,1,1,0,1,1,1; parity 1; stop 1; tx_done pulses once; busy drops after the lines go idle.
- Send 0x01 and 0xFF -> parity bit 0 and 1 respectively; clk held low for exactly 8 cycles before data_oe rises.
- Device omits ack (data stays 1 on 11th falling edge) -> tx_error pulses once; tx_done stays 0; IDLE afterwards.
- Device never clocks after request -> tx_error exactly 2000 cycles after clk release; both oe=0.
- tx_valid held with PS2_data held low externally -> tx_ready=0, no transfer; release data -> accepted 3 cycles later.
- Assert reset after bit 4 -> both oe=0 in the same cycle; after reset release a new byte 0xF4 sends correctly.
